pulse_readback: RTL

PULSE_READBACK -- requirements
Module: pulse_readback

---
 rtl/pulse_readback_if.sv | 22 ++
 rtl/pulse_readback.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_readback_if.sv
// Request/UART handshake bundle for pulse_readback: the readback request side
// (req/sel/busy/done/timeout_err) and the UART byte side (transmit/tx_byte/is_transmitting).
interface pulse_readback_if;
  logic       req;
  logic [2:0] sel;
  logic       is_transmitting;
  logic       transmit;
  logic [7:0] tx_byte;
  logic       busy;
  logic       done;
  logic       timeout_err;

  modport master (
    output req, sel, is_transmitting,
    input  transmit, tx_byte, busy, done, timeout_err
  );

  modport slave (
    input  req, sel, is_transmitting,
    output transmit, tx_byte, busy, done, timeout_err
  );
endinterface

// File: rtl/pulse_readback.sv
// Pulse-parameter readback: snapshots one 32-bit parameter word on req and streams it
// to a UART as data bytes, the sel byte and (with READBACK_CHECKSUM_EN) a checksum byte.
module pulse_readback #(
  parameter int unsigned TX_START_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pulse_readback_if.slave   bus,
  input  logic [31:0]       del,
  input  logic [31:0]       per,
  input  logic [31:0]       p1wid,
  input  logic [31:0]       p2wid,
  input  logic [31:0]       pbwid,
  input  logic [31:0]       offr_d,
  input  logic [6:0]        pp_pu,
  input  logic [6:0]        pp_pr,
  input  logic [6:0]        p_att,
  input  logic [7:0]        p_bl,
  input  logic              pu,
  input  logic              doub,
  input  logic              bl
);

`ifdef READBACK_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd5;
`else
  localparam logic [2:0] LAST_IDX = 3'd4;
`endif
  localparam int unsigned TW = $clog2(TX_START_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_SEND       = 3'd2,
    S_WAIT_START = 3'd3,
    S_WAIT_DONE  = 3'd4,
    S_FINISH     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  shadow_sel_q, shadow_sel_d;
  logic [2:0]  idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic        transmit_q, transmit_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        timeout_err_q, timeout_err_d;
  logic [31:0] sel_word_s;

`ifdef READBACK_CHECKSUM_EN
  function automatic logic [7:0] checksum8(input logic [31:0] w);
    checksum8 = w[7:0] + w[15:8] + w[23:16] + w[31:24];
  endfunction
`endif

  function automatic logic [7:0] packet_byte(input logic [31:0] w, input logic [2:0] s,
                                             input logic [2:0] idx);
    case (idx)
      3'd0:    packet_byte = w[7:0];
      3'd1:    packet_byte = w[15:8];
      3'd2:    packet_byte = w[23:16];
      3'd3:    packet_byte = w[31:24];
      3'd4:    packet_byte = {5'b00000, s};
`ifdef READBACK_CHECKSUM_EN
      3'd5:    packet_byte = checksum8(w);
`endif
      default: packet_byte = 8'h00;
    endcase
  endfunction

  // Live parameter word for the requested sel; codes 4 and 6 mirror the write-side packing.
  always_comb begin
    sel_word_s = 32'h0000_0000;
    case (bus.sel)
      3'd0:    sel_word_s = del;
      3'd1:    sel_word_s = per;
      3'd2:    sel_word_s = p1wid;
      3'd3:    sel_word_s = p2wid;
      3'd4:    sel_word_s = {16'h0000, p_bl, 5'b00000, bl, doub, pu};
      3'd5:    sel_word_s = pbwid;
      3'd6:    sel_word_s = {8'h00, 1'b0, pp_pu, 1'b0, p_att, 1'b0, pp_pr};
      3'd7:    sel_word_s = offr_d;
      default: sel_word_s = 32'h0000_0000;
    endcase
  end

  // Next-state and next-output logic; outputs are computed one state ahead so they are registered.
  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    shadow_sel_d  = shadow_sel_q;
    idx_d         = idx_q;
    timer_d       = timer_q;
    transmit_d    = 1'b0;
    tx_byte_d     = tx_byte_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    timeout_err_d = timeout_err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          data_d        = sel_word_s;
          shadow_sel_d  = bus.sel;
          idx_d         = 3'd0;
          tx_byte_d     = packet_byte(sel_word_s, bus.sel, 3'd0);
          busy_d        = 1'b1;
          timeout_err_d = 1'b0;
          state_d       = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: state_d = S_SEND;
      S_SEND: begin
        if (!bus.is_transmitting) begin
          transmit_d = 1'b1;
          timer_d    = '0;
          state_d    = S_WAIT_START;
        end else begin
          state_d = S_SEND;
        end
      end
      S_WAIT_START: begin
        if (bus.is_transmitting) begin
          state_d = S_WAIT_DONE;
        end else if (timer_q == TW'(TX_START_TIMEOUT - 1)) begin
          // UART never picked the byte up: give up on the whole packet
          timeout_err_d = 1'b1;
          busy_d        = 1'b0;
          done_d        = 1'b1;
          state_d       = S_FINISH;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!bus.is_transmitting) begin
          if (idx_q == LAST_IDX) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FINISH;
          end else begin
            idx_d     = idx_q + 3'd1;
            tx_byte_d = packet_byte(data_q, shadow_sel_q, idx_q + 3'd1);
            state_d   = S_SEND;
          end
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      data_q        <= 32'h0000_0000;
      shadow_sel_q  <= 3'd0;
      idx_q         <= 3'd0;
      timer_q       <= '0;
      transmit_q    <= 1'b0;
      tx_byte_q     <= 8'h00;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      shadow_sel_q  <= shadow_sel_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      transmit_q    <= transmit_d;
      tx_byte_q     <= tx_byte_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.transmit    = transmit_q;
  assign bus.tx_byte     = tx_byte_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
